// File: rtl/ad_clock_gen.sv
// ad_clock_gen: CH_NUM fabric-divided ADC sample clocks with shadowed,
// boundary-applied reconfiguration and a PLL-style lock indicator.
module ad_clock_gen #(
  parameter int unsigned CH_NUM      = 2,
  parameter int unsigned DIV_W       = 10,
  parameter int unsigned DEF_RATIO   = 4,
  parameter int unsigned DEF_DUTY    = 2,
  parameter int unsigned DEF_PHASE   = 0,
  parameter int unsigned LOCK_CYCLES = 64,
  localparam int unsigned CH_W       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic              clkin1,
  input  logic              rst,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_ratio,
  input  logic [DIV_W-1:0]  cfg_duty,
  input  logic [DIV_W-1:0]  cfg_phase,
  output logic              cfg_ready,
  output logic              cfg_err,
  input  logic              sync,
  output logic [CH_NUM-1:0] clkout,
  output logic [CH_NUM-1:0] sample_en,
  output logic              pll_lock
);

  localparam int unsigned LK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic [1:0] {ALIGN, SETTLE, LOCKED} lock_state_t;

  lock_state_t       state;
  logic [LK_W-1:0]   settle_cnt;

  logic [DIV_W-1:0]  ratio    [CH_NUM];
  logic [DIV_W-1:0]  duty     [CH_NUM];
  logic [DIV_W-1:0]  phase    [CH_NUM];
  logic [DIV_W-1:0]  sh_ratio [CH_NUM];
  logic [DIV_W-1:0]  sh_duty  [CH_NUM];
  logic [DIV_W-1:0]  sh_phase [CH_NUM];
  logic [DIV_W-1:0]  cnt      [CH_NUM];
  logic [CH_NUM-1:0] pending;

  logic [(1<<CH_W)-1:0] ch_valid;
  logic                 wr_ok;
  logic                 sync_all;
  logic                 pend_keep;
  logic                 lock_event;
  logic [CH_NUM-1:0]    wr_hit;
  logic [CH_NUM-1:0]    at_end;
  logic [CH_NUM-1:0]    apply;

  // Write validation, period-end detection and boundary-apply decode.
  always_comb begin
    ch_valid = '0;
    wr_hit   = '0;
    at_end   = '0;
    apply    = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      ch_valid[i] = 1'b1;
    end
    wr_ok = cfg_wr && cfg_ready && ch_valid[cfg_ch] &&
            (cfg_ratio > DIV_W'(1)) && (cfg_duty != '0) &&
            (cfg_duty < cfg_ratio) && (cfg_phase < cfg_ratio);
    // The ALIGN cycle behaves exactly like an external sync.
    sync_all = sync || (state == ALIGN);
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      wr_hit[i] = wr_ok && (cfg_ch == CH_W'(i));
      at_end[i] = (cnt[i] == ratio[i] - DIV_W'(1));
      apply[i]  = pending[i] && at_end[i] && !sync_all;
    end
    pend_keep  = |(pending & ~apply);
    lock_event = sync || (|apply);
  end

  // Per-channel divider, shadow configuration and registered outputs.
  always_ff @(posedge clkin1) begin
    if (rst) begin
      pending   <= '0;
      clkout    <= '0;
      sample_en <= '0;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        ratio[i]    <= DIV_W'(DEF_RATIO);
        duty[i]     <= DIV_W'(DEF_DUTY);
        phase[i]    <= DIV_W'(DEF_PHASE);
        sh_ratio[i] <= DIV_W'(DEF_RATIO);
        sh_duty[i]  <= DIV_W'(DEF_DUTY);
        sh_phase[i] <= DIV_W'(DEF_PHASE);
        cnt[i]      <= DIV_W'(DEF_PHASE);
      end
    end else begin
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        clkout[i]    <= (state != ALIGN) && (cnt[i] < duty[i]);
        sample_en[i] <= (state != ALIGN) && at_end[i];
        if (sync_all) begin
          pending[i] <= 1'b0;
          if (wr_hit[i]) begin
            ratio[i] <= cfg_ratio;
            duty[i]  <= cfg_duty;
            phase[i] <= cfg_phase;
            cnt[i]   <= cfg_phase;
          end else if (pending[i]) begin
            ratio[i] <= sh_ratio[i];
            duty[i]  <= sh_duty[i];
            phase[i] <= sh_phase[i];
            cnt[i]   <= sh_phase[i];
          end else begin
            cnt[i] <= phase[i];
          end
        end else if (apply[i]) begin
          ratio[i]   <= sh_ratio[i];
          duty[i]    <= sh_duty[i];
          phase[i]   <= sh_phase[i];
          cnt[i]     <= '0;
          pending[i] <= 1'b0;
        end else begin
          cnt[i] <= at_end[i] ? '0 : cnt[i] + DIV_W'(1);
          if (wr_hit[i]) begin
            sh_ratio[i] <= cfg_ratio;
            sh_duty[i]  <= cfg_duty;
            sh_phase[i] <= cfg_phase;
            pending[i]  <= 1'b1;
          end
        end
      end
    end
  end

  // Config handshake status and lock state machine.
  always_ff @(posedge clkin1) begin
    if (rst) begin
      state      <= ALIGN;
      settle_cnt <= '0;
      pll_lock   <= 1'b0;
      cfg_ready  <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err   <= cfg_wr && !wr_ok;
      // A write captured by a sync leaves nothing pending but still costs one cycle of ready.
      cfg_ready <= !(wr_ok || (!sync_all && pend_keep));
      case (state)
        ALIGN: begin
          state      <= SETTLE;
          settle_cnt <= '0;
          pll_lock   <= 1'b0;
        end
        SETTLE: begin
          if (lock_event) begin
            settle_cnt <= '0;
          end else if (settle_cnt == LK_W'(LOCK_CYCLES - 1)) begin
            state    <= LOCKED;
            pll_lock <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + LK_W'(1);
          end
        end
        LOCKED: begin
          if (lock_event) begin
            state      <= SETTLE;
            settle_cnt <= '0;
            pll_lock   <= 1'b0;
          end
        end
        default: begin
          state      <= ALIGN;
          settle_cnt <= '0;
          pll_lock   <= 1'b0;
        end
      endcase
    end
  end

endmodule
